// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues word fetches over a valid/ready port and
// presents the fetched instruction to decode. Optional macro: FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        dec_ready,
   output logic [31:0] instruction,
   output logic [5:0]  opcode,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        branch_taken,
   input  logic [31:0] imm_ext,
   input  logic        jump,
   input  logic [25:0] jump_target,
   output logic [31:0] perf_retired
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        vld_q, vld_d;
   logic [31:0] next_pc;

   assign pc_out      = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign instruction = instr_q;
   assign opcode      = instr_q[31:26];
   assign instr_valid = vld_q;
   assign imem_addr   = pc_q;
   // Gated by reset so no request is visible while the core is held in reset.
   assign imem_req_valid = (state_q == S_FETCH) && !reset;

   // Jump wins over a taken branch.
   always_comb begin
      next_pc = pc_plus4;
      if (jump)
         next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      else if (branch_taken)
         next_pc = pc_plus4 + (imm_ext << 2);
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      vld_d   = vld_q;
      case (state_q)
         S_FETCH: if (imem_req_ready) state_d = S_WAIT;
         S_WAIT: begin
            if (imem_rsp_valid) begin
               instr_d = imem_rdata;
               vld_d   = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (dec_ready) begin
               pc_d    = next_pc;
               vld_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: begin
            vld_d   = 1'b0;
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         vld_q   <= vld_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic        retire;
   logic [31:0] perf_q;

   assign retire = (state_q == S_HOLD) && dec_ready;

   always_ff @(posedge clk) begin
      if (reset)
         perf_q <= '0;
      else if (retire)
         perf_q <= perf_q + 32'd1;
   end

   assign perf_retired = perf_q;
`else
   assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level reference model, directed
// scenarios pinned with literal addresses, then randomized traffic.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0040;
`ifdef FETCH_PERF_CNT_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic        instr_valid, dec_ready;
   logic [31:0] instruction;
   logic [5:0]  opcode;
   logic [31:0] pc_out, pc_plus4;
   logic        branch_taken;
   logic [31:0] imm_ext;
   logic        jump;
   logic [25:0] jump_target;
   logic [31:0] perf_retired;

   instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .dec_ready(dec_ready), .instruction(instruction), .opcode(opcode),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .branch_taken(branch_taken),
      .imm_ext(imm_ext), .jump(jump), .jump_target(jump_target),
      .perf_retired(perf_retired)
   );

   always #5 clk = ~clk;

   // Reference model: where the next fetch goes and what decode should see.
   logic [31:0] exp_pc, exp_instr, exp_retired;
   bit          outstanding, holding, rst_cur;
   int          n_cmp = 0, n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_pc      = RST_PC;
      exp_instr   = '0;
      exp_retired = '0;
      outstanding = 1'b0;
      holding     = 1'b0;
   endtask

   // Called at negedge: check outputs, apply inputs for next posedge, advance model.
   task automatic step(input bit rst, input bit rdy, input bit rsp, input logic [31:0] rd,
                       input bit dec, input bit br, input logic [31:0] imm,
                       input bit j, input logic [25:0] tgt);
      logic [31:0] p4;
      bit idle;
      idle = !outstanding && !holding;
      check("req_valid", {31'd0, imem_req_valid}, {31'd0, !rst_cur && idle});
      if (!rst_cur && idle) check("req_addr", imem_addr, exp_pc);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, holding});
      if (holding) begin
         check("instruction", instruction, exp_instr);
         check("opcode", {26'd0, opcode}, {26'd0, exp_instr[31:26]});
         check("pc_out", pc_out, exp_pc);
         check("pc_plus4", pc_plus4, exp_pc + 32'd4);
      end
      if (outstanding) check("pc_out_wait", pc_out, exp_pc);
      check("perf_retired", perf_retired, PERF_ON ? exp_retired : 32'd0);

      reset = rst; imem_req_ready = rdy; imem_rsp_valid = rsp; imem_rdata = rd;
      dec_ready = dec; branch_taken = br; imm_ext = imm; jump = j; jump_target = tgt;

      if (rst) model_reset();
      else if (idle) begin
         if (rdy) outstanding = 1'b1;
      end else if (outstanding) begin
         if (rsp) begin outstanding = 1'b0; holding = 1'b1; exp_instr = rd; end
      end else if (dec) begin
         holding = 1'b0;
         exp_retired = exp_retired + 32'd1;
         p4 = exp_pc + 32'd4;
         if (j) exp_pc = {p4[31:28], tgt, 2'b00};
         else if (br) exp_pc = p4 + (imm << 2);
         else exp_pc = p4;
      end
      rst_cur = rst;
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full instruction with chosen stalls; redirect inputs are junk until retire.
   task automatic do_instr(input int rs, input int rdl, input int ds, input bit br,
                           input logic [31:0] imm, input bit j, input logic [25:0] tgt,
                           output int cyc);
      logic [31:0] a0;
      a0 = imem_addr;
      cyc = 0;
      for (int k = 0; k < rs; k++) begin
         check("stall_addr", imem_addr, a0);
         check("stall_valid", {31'd0, imem_req_valid}, 32'd1);
         step(0, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom); cyc++;
      end
      step(0, 1, 0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom); cyc++;
      for (int k = 0; k < rdl; k++) begin
         step(0, $urandom, 0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom); cyc++;
      end
      step(0, $urandom, 1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom); cyc++;
      for (int k = 0; k < ds; k++) begin
         step(0, $urandom, k[0], $urandom, 0, $urandom, $urandom, $urandom, $urandom); cyc++;
      end
      step(0, $urandom, 0, $urandom, 1, br, imm, j, tgt); cyc++;
   endtask

   initial begin
      int cyc;
      logic [31:0] held;
      reset = 1'b1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rdata = '0;
      dec_ready = 0; branch_taken = 0; imm_ext = '0; jump = 0; jump_target = '0;
      model_reset();
      rst_cur = 1'b1;
      @(posedge clk); @(negedge clk);
      step(1, 1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rst_addr", imem_addr, 32'h0000_0040);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instruction", instruction, 32'd0);
      check("rst_perf", perf_retired, 32'd0);

      // 0x40 with request backpressure, branch back to 0xFFFF_FFFC
      do_instr(3, 0, 0, 1, 32'hFFFF_FFEE, 0, 0, cyc);
      check("br_neg_wrap", imem_addr, 32'hFFFF_FFFC);
      do_instr(0, 0, 0, 0, 0, 0, 0, cyc);
      check("seq_wrap", imem_addr, 32'h0000_0000);
      do_instr(0, 0, 0, 0, 0, 0, 0, cyc);
      check("seq_0", imem_addr, 32'h0000_0004);
      check("latency", cyc, 3);
      check("perf_3", perf_retired, PERF_ON ? 32'd3 : 32'd0);
      do_instr(0, 0, 0, 0, 0, 0, 0, cyc);
      check("seq_4", imem_addr, 32'h0000_0008);
      do_instr(0, 1, 0, 0, 0, 1, 26'h4, cyc);
      check("jump_10", imem_addr, 32'h0000_0010);
      do_instr(0, 0, 0, 1, 32'h0000_0003, 0, 0, cyc);
      check("br_pos", imem_addr, 32'h0000_0020);
      do_instr(0, 0, 0, 0, 0, 1, 26'h4, cyc);
      do_instr(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, cyc);
      check("br_neg", imem_addr, 32'h0000_000C);
      do_instr(0, 0, 0, 0, 0, 1, 26'h4, cyc);
      do_instr(0, 0, 0, 1, 32'h03FF_FFFB, 0, 0, cyc);
      check("br_far", imem_addr, 32'h1000_0000);

      // Decode stall with spurious responses, then jump overriding branch
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0);
      held = instruction;
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 1, $urandom, 0, 0, 0, 0, 0);
         check("hold_instr", instruction, 32'h1234_5678);
      end
      check("hold_stable", instruction, held);
      step(0, 0, 0, 0, 1, 1, 32'h0000_0100, 1, 26'h40);
      check("jump_prio", imem_addr, 32'h1000_0100);

      // Reset while waiting on a response, stale response afterwards
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'hBAD0_BAD0, 1, 0, 0, 0, 0);
      check("stale_addr", imem_addr, 32'h0000_0040);
      check("stale_valid", {31'd0, instr_valid}, 32'd0);
      check("stale_perf", perf_retired, 32'd0);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] imm;
         imm = ($urandom_range(0, 3) == 0) ? $urandom : (32'($signed(8'($urandom))));
         step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
              outstanding ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0),
              $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, imm,
              $urandom_range(0, 3) == 0, 26'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
